cache_fill_fsm: RTL and testbench

Miss-handling controller for the cache between the single-cycle core and a multi-cycle main memory. On a miss it captures the block address, fetches every word of the block from main memory, and streams each returned word into the cache data array with a word index. It writes the tag array when the last word lands, then releases the core. Instruction-side and data-side caches each instantiate one copy, and `fsm_busy` drives the core's global stall.

---
 rtl/cache_fill_fsm.sv | 115 +++++++++++
 tb/tb_cache_fill_fsm.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: captures the block base on a miss, fetches every word, then writes the tag.
// CACHE_FILL_PIPELINED_EN selects back-to-back request issue; without it one request is outstanding at a time.
module cache_fill_fsm #(
   parameter int BLOCK_WORDS = 8,
   parameter int ADDR_W      = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           miss_detected,
   input  logic [ADDR_W-1:0]              miss_address,
   input  logic                           memory_data_valid,
   input  logic [15:0]                    memory_data,
   output logic                           fsm_busy,
   output logic                           mem_req,
   output logic [ADDR_W-1:0]              memory_address,
   output logic                           write_data_array,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
   output logic [15:0]                    fill_data,
   output logic                           write_tag_array,
   output logic [ADDR_W-1:0]              fill_base
);

   localparam int IDX_W = $clog2(BLOCK_WORDS);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(BLOCK_WORDS - 1);
   localparam logic [CNT_W-1:0]  ALL_WORDS = CNT_W'(BLOCK_WORDS);
   // A block spans 2*BLOCK_WORDS bytes, so CNT_W low address bits are the byte offset.
   localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << CNT_W;

   typedef enum logic {IDLE, FILL} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]    recv_cnt_q, recv_cnt_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W-1:0]   issue_off;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
         base_q      <= '0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         recv_cnt_q  <= recv_cnt_d;
         base_q      <= base_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      issue_cnt_d      = issue_cnt_q;
      recv_cnt_d       = recv_cnt_q;
      base_d           = base_q;
      fsm_busy         = 1'b0;
      mem_req          = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      fill_word        = '0;
      write_tag_array  = 1'b0;
      issue_off        = '0;
      issue_off[CNT_W:1] = issue_cnt_q;

      case (state_q)
         IDLE: begin
            fsm_busy = miss_detected;
            if (miss_detected) begin
               base_d      = miss_address & BASE_MASK;
               issue_cnt_d = '0;
               recv_cnt_d  = '0;
               state_d     = FILL;
            end
         end
         FILL: begin
            fsm_busy       = 1'b1;
            memory_address = base_q + issue_off;
`ifdef CACHE_FILL_PIPELINED_EN
            mem_req = (issue_cnt_q < ALL_WORDS);
`else
            // Issue only when every earlier request has returned its word.
            mem_req = (issue_cnt_q == recv_cnt_q) && (issue_cnt_q < ALL_WORDS);
`endif
            if (mem_req) begin
               issue_cnt_d = issue_cnt_q + 1'b1;
            end
            if (memory_data_valid) begin
               write_data_array = 1'b1;
               fill_word        = recv_cnt_q[IDX_W-1:0];
               recv_cnt_d       = recv_cnt_q + 1'b1;
               if (recv_cnt_q == LAST_WORD) begin
                  write_tag_array = 1'b1;
                  state_d         = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Reset holds every output low, including the combinational miss-cycle stall.
      if (!rst_n) begin
         fsm_busy         = 1'b0;
         mem_req          = 1'b0;
         memory_address   = '0;
         write_data_array = 1'b0;
         fill_word        = '0;
         write_tag_array  = 1'b0;
      end
   end

   assign fill_data = rst_n ? memory_data : 16'h0000;
   assign fill_base = base_q;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a latency-L memory model answers requests; per-cycle expectations come from the fill rules.
module tb_cache_fill_fsm;

   localparam int BW = 8;
`ifdef CACHE_FILL_PIPELINED_EN
   localparam bit PIPE = 1'b1;
`else
   localparam bit PIPE = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        memory_data_valid;
   logic [15:0] memory_data;
   logic        fsm_busy;
   logic        mem_req;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic [2:0]  fill_word;
   logic [15:0] fill_data;
   logic        write_tag_array;
   logic [15:0] fill_base;

   int total;
   int bad;
   logic [15:0] mem [0:32767];

   cache_fill_fsm #(.BLOCK_WORDS(BW), .ADDR_W(16)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data_valid (memory_data_valid),
      .memory_data       (memory_data),
      .fsm_busy          (fsm_busy),
      .mem_req           (mem_req),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .fill_word         (fill_word),
      .fill_data         (fill_data),
      .write_tag_array   (write_tag_array),
      .fill_base         (fill_base)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_all_zero(input string tag);
      total++;
      if ({fsm_busy, mem_req, memory_address, write_data_array, fill_word,
           fill_data, write_tag_array, fill_base} !== '0) begin
         bad++;
         $display("FAIL %s: outputs busy=%b req=%b addr=%h wr=%b word=%0d data=%h tag=%b base=%h, required all zero",
                  tag, fsm_busy, mem_req, memory_address, write_data_array, fill_word,
                  fill_data, write_tag_array, fill_base);
      end
   endtask

   // One fill from the miss cycle (c=0). abort_at>=0 pulls reset in that cycle;
   // b2b ends on the tag-write cycle so the caller can miss again straight away.
   task automatic run_fill(input logic [15:0] addr, input int lat, input bit inj_miss,
                           input int abort_at, input bit b2b);
      logic [15:0] base;
      logic [15:0] pend_addr[$];
      int          pend_due[$];
      int          reqs, writes, exp_end, last_c;
      bit          done, exp_req, exp_wr, exp_tag, exp_busy, aborted;
      logic [15:0] drv_data, exp_addr;
      base    = addr & 16'hFFF0;
      reqs    = 0;
      writes  = 0;
      done    = 0;
      aborted = 0;
      exp_end = PIPE ? (BW + lat) : (BW * (lat + 1));
      last_c  = b2b ? exp_end : exp_end + 1;
      for (int c = 0; c <= last_c; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) begin
            miss_detected = 1'b1;
            miss_address  = addr;
         end else begin
            miss_detected = inj_miss && (c < exp_end) && ($urandom_range(0, 1) == 1);
            miss_address  = 16'h4000;
         end
         if (pend_due.size() > 0 && pend_due[0] == c) begin
            memory_data_valid = 1'b1;
            drv_data          = mem[pend_addr[0][15:1]];
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
         end else begin
            memory_data_valid = 1'b0;
            drv_data          = 16'($urandom);
         end
         memory_data = drv_data;
         if (c == abort_at) rst_n = 1'b0;
         @(negedge clk);
         if (c == abort_at) begin
            check_all_zero("reset_mid_fill");
            aborted = 1;
            break;
         end
         exp_busy = !done;
         if (c == 0 || done) exp_req = 0;
         else if (PIPE)      exp_req = (reqs < BW);
         else                exp_req = (reqs == writes) && (reqs < BW);
         exp_wr   = memory_data_valid && !done && (c > 0);
         exp_tag  = exp_wr && (writes == BW - 1);
         exp_addr = 16'(base + 2 * reqs);
         total++;
         if (fsm_busy !== exp_busy) begin
            bad++;
            $display("FAIL busy c=%0d: got %b want %b", c, fsm_busy, exp_busy);
         end
         total++;
         if (mem_req !== exp_req) begin
            bad++;
            $display("FAIL mem_req c=%0d: got %b want %b", c, mem_req, exp_req);
         end
         if (exp_req) begin
            total++;
            if (memory_address !== exp_addr) begin
               bad++;
               $display("FAIL req_addr c=%0d: got %h want %h", c, memory_address, exp_addr);
            end
         end
         total++;
         if (write_data_array !== exp_wr) begin
            bad++;
            $display("FAIL write_data c=%0d: got %b want %b", c, write_data_array, exp_wr);
         end
         if (exp_wr) begin
            total++;
            if (fill_word !== 3'(writes) || fill_data !== drv_data) begin
               bad++;
               $display("FAIL fill_word_data c=%0d: got %0d/%h want %0d/%h",
                        c, fill_word, fill_data, writes, drv_data);
            end
         end
         total++;
         if (write_tag_array !== exp_tag) begin
            bad++;
            $display("FAIL write_tag c=%0d: got %b want %b", c, write_tag_array, exp_tag);
         end
         if (c > 0) begin
            total++;
            if (fill_base !== base) begin
               bad++;
               $display("FAIL fill_base c=%0d: got %h want %h", c, fill_base, base);
            end
         end
         if (exp_req) begin
            pend_due.push_back(c + lat);
            pend_addr.push_back(exp_addr);
            reqs++;
         end
         if (exp_wr) writes++;
         if (exp_tag) begin
            done = 1;
            total++;
            if (c != exp_end) begin
               bad++;
               $display("FAIL tag_cycle: got %0d want %0d", c, exp_end);
            end
         end
      end
      if (aborted) begin
         repeat (2) @(posedge clk);
         #1;
         rst_n             = 1'b1;
         miss_detected     = 1'b0;
         memory_data_valid = 1'b0;
      end else begin
         total++;
         if (!done) begin
            bad++;
            $display("FAIL fill_complete: got %0d words want %0d", writes, BW);
         end
         if (!b2b) begin
            @(posedge clk);
            #1;
            miss_detected     = 1'b0;
            memory_data_valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      rst_n             = 1'b0;
      miss_detected     = 1'b1;
      miss_address      = 16'h1234;
      memory_data_valid = 1'b1;
      memory_data       = 16'hBEEF;
      repeat (3) begin
         @(negedge clk);
         check_all_zero("in_reset");
      end
      @(posedge clk);
      #1;
      miss_detected     = 1'b0;
      memory_data_valid = 1'b0;
      memory_data       = 16'h0000;
      rst_n             = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_all_zero("idle_after_reset");
      end
   endtask

   task automatic test_stray_valid;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         memory_data_valid = ($urandom_range(0, 1) == 1);
         memory_data       = 16'($urandom);
         @(negedge clk);
         total++;
         if (write_data_array !== 1'b0 || write_tag_array !== 1'b0 || fsm_busy !== 1'b0
             || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL stray_valid: wr=%b tag=%b busy=%b req=%b want all 0",
                     write_data_array, write_tag_array, fsm_busy, mem_req);
         end
      end
      @(posedge clk);
      #1;
      memory_data_valid = 1'b0;
   endtask

   task automatic test_basic;
      run_fill(16'h1234, 4, 1'b0, -1, 1'b0);
   endtask

   task automatic test_wrap;
      run_fill(16'hFFFF, 4, 1'b0, -1, 1'b0);
   endtask

   task automatic test_ignore_miss;
      run_fill(16'h5678, 3, 1'b1, -1, 1'b0);
      test_stray_valid();
   endtask

   task automatic test_reset_mid_fill;
      run_fill(16'h0ABC, 4, 1'b0, 6, 1'b0);
      run_fill(16'h0020, 4, 1'b0, -1, 1'b0);
   endtask

   task automatic test_back_to_back;
      run_fill(16'($urandom), $urandom_range(1, 6), 1'b0, -1, 1'b1);
      run_fill(16'($urandom), $urandom_range(1, 6), 1'b0, -1, 1'b0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 6; i++) begin
         run_fill(16'($urandom), $urandom_range(1, 7), ($urandom_range(0, 1) == 1), -1, 1'b0);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
      test_reset();
      test_stray_valid();
      test_basic();
      test_wrap();
      test_ignore_miss();
      test_reset_mid_fill();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
